// File: rtl/riscv_pkg.sv
// Shared RISC-V pipeline definitions: load/store funct3 encodings, LSU FSM states,
// and the funct3 legality / alignment helpers used by the memory stage.
package riscv_pkg;

   localparam logic [2:0] F3_LB  = 3'b000;
   localparam logic [2:0] F3_LH  = 3'b001;
   localparam logic [2:0] F3_LW  = 3'b010;
   localparam logic [2:0] F3_LBU = 3'b100;
   localparam logic [2:0] F3_LHU = 3'b101;
   localparam logic [2:0] F3_SB  = 3'b000;
   localparam logic [2:0] F3_SH  = 3'b001;
   localparam logic [2:0] F3_SW  = 3'b010;

   typedef enum logic [1:0] {IDLE, WAIT, DONE} lsu_state_t;

   function automatic logic f3_legal(input logic is_load, input logic [2:0] f3);
      if (is_load)
         return (f3 == F3_LB) || (f3 == F3_LH) || (f3 == F3_LW) ||
                (f3 == F3_LBU) || (f3 == F3_LHU);
      else
         return (f3 == F3_SB) || (f3 == F3_SH) || (f3 == F3_SW);
   endfunction

   // funct3[1:0] encodes access size for both loads and stores.
   function automatic logic f3_misaligned(input logic [2:0] f3, input logic [1:0] off);
      return ((f3[1:0] == 2'b01) && off[0]) || ((f3[1:0] == 2'b10) && (off != 2'b00));
   endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: store byte enables and data replication, and
// load lane selection with sign/zero extension.
module lsu_align
   import riscv_pkg::*;
(
   input  logic        i_st_is_read,
   input  logic [2:0]  i_st_funct3,
   input  logic [1:0]  i_st_off,
   input  logic [31:0] i_st_data,
   output logic [3:0]  o_be,
   output logic [31:0] o_wdata,
   input  logic [2:0]  i_ld_funct3,
   input  logic [1:0]  i_ld_off,
   input  logic [31:0] i_rdata,
   output logic [31:0] o_ld_data
);

   logic [7:0]  w_byte;
   logic [15:0] w_half;

   always_comb begin
      o_be    = 4'b1111;
      o_wdata = i_st_data;
      if (!i_st_is_read) begin
         unique case (i_st_funct3)
            F3_SB: begin
               o_be    = 4'b0001 << i_st_off;
               o_wdata = {4{i_st_data[7:0]}};
            end
            F3_SH: begin
               o_be    = 4'b0011 << {i_st_off[1], 1'b0};
               o_wdata = {2{i_st_data[15:0]}};
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      w_byte    = i_rdata[8*i_ld_off +: 8];
      w_half    = i_ld_off[1] ? i_rdata[31:16] : i_rdata[15:0];
      o_ld_data = i_rdata;
      unique case (i_ld_funct3)
         F3_LB:   o_ld_data = {{24{w_byte[7]}}, w_byte};
         F3_LH:   o_ld_data = {{16{w_half[15]}}, w_half};
         F3_LBU:  o_ld_data = {24'b0, w_byte};
         F3_LHU:  o_ld_data = {16'b0, w_half};
         default: o_ld_data = i_rdata;
      endcase
   end

endmodule

// File: rtl/mem_stage_lsu.sv
// Memory-stage load/store unit: single-outstanding IDLE/WAIT/DONE bus FSM that
// stalls the pipeline until the data bus acknowledges.
module mem_stage_lsu
   import riscv_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        valid_m,
   input  logic        mem_read_m,
   input  logic        mem_write_m,
   input  logic [2:0]  funct3_m,
   input  logic [31:0] addr_m,
   input  logic [31:0] write_data_m,
   output logic        stall_m,
   output logic [31:0] load_data_m,
   output logic        misaligned_m,
   output logic        bus_req,
   output logic        bus_we,
   output logic [31:0] bus_addr,
   output logic [31:0] bus_wdata,
   output logic [3:0]  bus_be,
   input  logic        bus_ack,
   input  logic [31:0] bus_rdata
);

   lsu_state_t  r_state, w_next;
   logic        r_we, r_rd;
   logic [31:0] r_addr, r_wdata, r_ldata;
   logic [3:0]  r_be;
   logic [1:0]  r_off;
   logic [2:0]  r_f3;

   logic        w_req, w_legal, w_mis, w_access;
   logic [3:0]  w_be;
   logic [31:0] w_wdata, w_ld;

   // Read wins when both request bits are set.
   assign w_req    = valid_m & (mem_read_m | mem_write_m);
   assign w_legal  = f3_legal(mem_read_m, funct3_m);
   assign w_mis    = f3_misaligned(funct3_m, addr_m[1:0]);
   assign w_access = w_req & w_legal & ~w_mis;

   lsu_align u_align (
      .i_st_is_read (mem_read_m),
      .i_st_funct3  (funct3_m),
      .i_st_off     (addr_m[1:0]),
      .i_st_data    (write_data_m),
      .o_be         (w_be),
      .o_wdata      (w_wdata),
      .i_ld_funct3  (r_f3),
      .i_ld_off     (r_off),
      .i_rdata      (bus_rdata),
      .o_ld_data    (w_ld)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= IDLE;
         r_we    <= 1'b0;
         r_rd    <= 1'b0;
         r_addr  <= '0;
         r_wdata <= '0;
         r_be    <= '0;
         r_off   <= '0;
         r_f3    <= '0;
         r_ldata <= '0;
      end else begin
         r_state <= w_next;
         if (r_state == IDLE && w_access) begin
            r_we    <= ~mem_read_m;
            r_rd    <= mem_read_m;
            r_addr  <= {addr_m[31:2], 2'b00};
            r_wdata <= w_wdata;
            r_be    <= w_be;
            r_off   <= addr_m[1:0];
            r_f3    <= funct3_m;
         end
         if (r_state == WAIT && bus_ack)
            r_ldata <= r_rd ? w_ld : '0;
      end
   end

   always_comb begin
      w_next      = r_state;
      stall_m     = 1'b0;
      bus_req     = 1'b0;
      load_data_m = '0;
      unique case (r_state)
         IDLE: begin
            stall_m = w_access;
            if (w_access) w_next = WAIT;
         end
         WAIT: begin
            stall_m = 1'b1;
            bus_req = 1'b1;
            if (bus_ack) w_next = DONE;
         end
         DONE: begin
            load_data_m = r_ldata;
            w_next      = IDLE;
         end
         default: w_next = IDLE;
      endcase
   end

   assign misaligned_m = w_req & w_legal & w_mis;
   assign bus_we       = r_we;
   assign bus_addr     = r_addr;
   assign bus_wdata    = r_wdata;
   assign bus_be       = r_be;

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Directed bench for mem_stage_lsu with hand-computed expectations.
module tb_mem_stage_lsu;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        valid_m = 1'b0, mem_read_m = 1'b0, mem_write_m = 1'b0;
   logic [2:0]  funct3_m = '0;
   logic [31:0] addr_m = '0, write_data_m = '0;
   logic        stall_m, misaligned_m, bus_req, bus_we;
   logic [31:0] load_data_m, bus_addr, bus_wdata;
   logic [3:0]  bus_be;
   logic        bus_ack = 1'b0;
   logic [31:0] bus_rdata = '0;

   int n_checks = 0;
   int n_errors = 0;
   int cyc = 0;
   int c0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   mem_stage_lsu dut (
      .clk(clk), .reset(reset), .valid_m(valid_m), .mem_read_m(mem_read_m),
      .mem_write_m(mem_write_m), .funct3_m(funct3_m), .addr_m(addr_m),
      .write_data_m(write_data_m), .stall_m(stall_m), .load_data_m(load_data_m),
      .misaligned_m(misaligned_m), .bus_req(bus_req), .bus_we(bus_we),
      .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_be(bus_be),
      .bus_ack(bus_ack), .bus_rdata(bus_rdata)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Called just after a rising edge with the FSM in IDLE; returns the same way.
   task automatic run(input string tag, input logic rd, input logic wr, input logic [2:0] f3,
                      input logic [31:0] addr, input logic [31:0] wd, input int nwait,
                      input logic [31:0] rdata, input logic [31:0] exp_ld,
                      input logic [3:0] exp_be, input logic [31:0] exp_wd, input logic exp_we);
      valid_m = 1'b1; mem_read_m = rd; mem_write_m = wr; funct3_m = f3;
      addr_m = addr; write_data_m = wd;
      @(negedge clk);
      check({tag, "_idle_stall"}, 32'(stall_m), 32'd1);
      check({tag, "_idle_req"}, 32'(bus_req), 32'd0);
      for (int i = 0; i < nwait; i++) begin
         @(posedge clk); #1;
         bus_ack   = (i == nwait - 1);
         bus_rdata = bus_ack ? rdata : 32'h5A5A_5A5A;
         @(negedge clk);
         check({tag, "_wait_req"}, 32'(bus_req), 32'd1);
         check({tag, "_wait_stall"}, 32'(stall_m), 32'd1);
         check({tag, "_be"}, 32'(bus_be), 32'(exp_be));
         check({tag, "_we"}, 32'(bus_we), 32'(exp_we));
         check({tag, "_addr"}, bus_addr, {addr[31:2], 2'b00});
         if (exp_we) check({tag, "_wdata"}, bus_wdata, exp_wd);
      end
      @(posedge clk); #1;
      bus_ack = 1'b0;
      @(negedge clk);
      check({tag, "_done_stall"}, 32'(stall_m), 32'd0);
      check({tag, "_done_req"}, 32'(bus_req), 32'd0);
      check({tag, "_load"}, load_data_m, exp_ld);
      @(posedge clk); #1;
   endtask

   task automatic idle_inputs();
      valid_m = 1'b0; mem_read_m = 1'b0; mem_write_m = 1'b0;
   endtask

   initial begin
      #2;
      check("rst_req", 32'(bus_req), 32'd0);
      check("rst_stall", 32'(stall_m), 32'd0);
      check("rst_be", 32'(bus_be), 32'd0);
      check("rst_addr", bus_addr, 32'd0);
      @(posedge clk); #1;
      reset = 1'b0;
      @(posedge clk); #1;

      run("lw", 1, 0, 3'b010, 32'h100, 0, 1, 32'hDEADBEEF, 32'hDEADBEEF, 4'b1111, 0, 0);
      run("lb", 1, 0, 3'b000, 32'h103, 0, 1, 32'h80FF_FFFF, 32'hFFFFFF80, 4'b1111, 0, 0);
      run("lbu", 1, 0, 3'b100, 32'h103, 0, 1, 32'h80FF_FFFF, 32'h00000080, 4'b1111, 0, 0);
      run("lh", 1, 0, 3'b001, 32'h102, 0, 2, 32'h8001_0000, 32'hFFFF8001, 4'b1111, 0, 0);
      run("lhu", 1, 0, 3'b101, 32'h102, 0, 1, 32'h8001_0000, 32'h00008001, 4'b1111, 0, 0);
      run("sh", 0, 1, 3'b001, 32'h22, 32'h1234ABCD, 4, 32'hFFFF_FFFF, 0, 4'b1100, 32'hABCDABCD, 1);
      run("sb", 0, 1, 3'b000, 32'h101, 32'h0000_00A5, 1, 0, 0, 4'b0010, 32'hA5A5A5A5, 1);
      run("rdwin", 1, 1, 3'b010, 32'h200, 32'h1111_1111, 1, 32'h7654_3210, 32'h76543210, 4'b1111, 0, 0);

      // Back-to-back SW then LW must take exactly six cycles.
      c0 = cyc;
      run("b2b_sw", 0, 1, 3'b010, 32'h40, 32'hCAFEF00D, 1, 0, 0, 4'b1111, 32'hCAFEF00D, 1);
      run("b2b_lw", 1, 0, 3'b010, 32'h44, 0, 1, 32'h0123_4567, 32'h01234567, 4'b1111, 0, 0);
      check("b2b_cycles", 32'(cyc - c0), 32'd6);
      idle_inputs();

      // Misaligned word load: flagged, no bus activity.
      valid_m = 1'b1; mem_read_m = 1'b1; funct3_m = 3'b010; addr_m = 32'h102;
      @(negedge clk);
      check("mis_flag", 32'(misaligned_m), 32'd1);
      check("mis_stall", 32'(stall_m), 32'd0);
      check("mis_load", load_data_m, 32'd0);
      @(posedge clk); #1;
      @(negedge clk);
      check("mis_req", 32'(bus_req), 32'd0);
      check("mis_stall2", 32'(stall_m), 32'd0);

      // Illegal funct3 on a load and a store.
      funct3_m = 3'b011; addr_m = 32'h100;
      @(negedge clk);
      check("ill_ld_stall", 32'(stall_m), 32'd0);
      check("ill_ld_mis", 32'(misaligned_m), 32'd0);
      mem_read_m = 1'b0; mem_write_m = 1'b1; funct3_m = 3'b100;
      @(posedge clk); #1;
      @(negedge clk);
      check("ill_st_stall", 32'(stall_m), 32'd0);
      check("ill_st_req", 32'(bus_req), 32'd0);
      idle_inputs();

      // Stray ack while idle is ignored.
      @(posedge clk); #1;
      bus_ack = 1'b1; bus_rdata = 32'hFFFF_FFFF;
      @(posedge clk); #1;
      bus_ack = 1'b0;
      @(negedge clk);
      check("stray_req", 32'(bus_req), 32'd0);
      check("stray_stall", 32'(stall_m), 32'd0);
      check("stray_load", load_data_m, 32'd0);

      // Reset during WAIT drops bus_req at once; a late ack is ignored.
      @(posedge clk); #1;
      valid_m = 1'b1; mem_read_m = 1'b1; funct3_m = 3'b010; addr_m = 32'h300;
      @(posedge clk); #1;
      @(negedge clk);
      check("rw_req_before", 32'(bus_req), 32'd1);
      idle_inputs();
      reset = 1'b1;
      #1;
      check("rw_req_async", 32'(bus_req), 32'd0);
      check("rw_stall_async", 32'(stall_m), 32'd0);
      @(posedge clk); #1;
      reset = 1'b0; bus_ack = 1'b1; bus_rdata = 32'h1234_5678;
      @(negedge clk);
      check("rw_req_ack", 32'(bus_req), 32'd0);
      check("rw_load_ack", load_data_m, 32'd0);
      @(posedge clk); #1;
      bus_ack = 1'b0;
      @(negedge clk);
      check("rw_no_done", load_data_m, 32'd0);
      check("rw_stall_end", 32'(stall_m), 32'd0);
      @(posedge clk); #1;

      // First access after reset release works normally.
      run("post_rst", 1, 0, 3'b000, 32'h301, 0, 1, 32'h0000_7F00, 32'h0000007F, 4'b1111, 0, 0);
      idle_inputs();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1);
   end

endmodule

// File: doc/mem_stage_lsu.md
MEM_STAGE_LSU -- requirements
Module: mem_stage_lsu

Interface
REQ-001 clk  in  1  pipeline clock; all state on rising edge.
REQ-002 reset  in  1  asynchronous, active-high; clock clk.
REQ-003 valid_m  in  1  instruction in M stage valid.
REQ-004 mem_read_m  in  1  load request.
REQ-005 mem_write_m  in  1  store request.
REQ-006 funct3_m  in  3  000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; stores 000 SB, 001 SH, 010 SW.
REQ-007 addr_m  in  32  byte address (ALU result).
REQ-008 write_data_m  in  32  store data (rs2).
REQ-009 stall_m  out  1  hold M stage and all upstream registers.
REQ-010 load_data_m  out  32  extended load result to M/W register.
REQ-011 misaligned_m  out  1  misaligned-access flag.
REQ-012 bus_req  out  1  data-bus request.
REQ-013 bus_we  out  1  1 = write.
REQ-014 bus_addr  out  32  word-aligned address, {addr_m[31:2],2'b00}.
REQ-015 bus_wdata  out  32  lane-replicated store data.
REQ-016 bus_be  out  4  byte enables.
REQ-017 bus_ack  in  1  bus completion, single-cycle pulse.
REQ-018 bus_rdata  in  32  read data, valid with bus_ack.

Function
REQ-019 access = valid_m & (mem_read_m | mem_write_m) & legal funct3 & aligned; when both read and write are set, read wins and write is ignored.
REQ-020 Illegal funct3 (011, 110, 111) causes no bus access: stall_m=0, load_data_m=0, misaligned_m=0.
REQ-021 Misaligned cases: halfword with addr_m[0]=1; word with addr_m[1:0]!=0. Result: misaligned_m=1, no bus access, stall_m=0, load_data_m=0.
REQ-022 FSM states:
  - IDLE: on access, stall_m=1 (combinational); next state is WAIT.
  - WAIT: bus_req=1, stall_m=1; on bus_ack, capture the extended read data and go to DONE; otherwise stay in WAIT.
  - DONE: stall_m=0, load_data_m=captured value; next state is IDLE.
REQ-023 Minimum latency is 3 cycles (IDLE, WAIT with immediate ack, DONE); each extra WAIT cycle adds 1.
REQ-024 bus_we, bus_addr, bus_wdata and bus_be come from registers loaded on the IDLE->WAIT transition and stay stable while bus_req=1.
REQ-025 bus_be: reads 1111; SB 0001<<addr[1:0]; SH 0011<<{addr[1],1'b0}; SW 1111.
REQ-026 bus_wdata: SB replicates byte[7:0] x4; SH replicates half[15:0] x2; SW passes through.
REQ-027 Load extraction uses the registered addr[1:0]:
  - LB/LH sign-extend the selected lane.
  - LBU/LHU zero-extend the selected lane.
  - LW passes through.
REQ-028 For stores, load_data_m=0 in DONE.
REQ-029 bus_ack outside WAIT is ignored.
REQ-030 In IDLE with no access, load_data_m=0 and stall_m=0.
REQ-031 Back-to-back accesses: after DONE, IDLE evaluates the next instruction in the following cycle; there is no bubble beyond the IDLE cycle.

Reset
REQ-032 Reset forces the state to IDLE and clears all registered outputs, bus_req, bus_we, bus_addr, bus_wdata, bus_be and the captured data.
REQ-033 Reset during WAIT drops bus_req immediately (async); any late bus_ack after reset is ignored.
REQ-034 After reset release, the first rising edge may start a new access.

Structure
REQ-035 Shared package riscv_pkg holds the funct3 load/store constants and the lsu_state_t enum {IDLE, WAIT, DONE}.
REQ-036 Combinational sub-module lsu_align performs byte-enable/wdata replication and load extraction/extension; mem_stage_lsu holds the FSM and registers.

Verification
REQ-037 LW, addr 0x100, ack on 1st WAIT cycle, rdata 0xDEADBEEF -> stall 1,1,0; load_data_m=0xDEADBEEF in DONE.
REQ-038 LB, addr 0x103, rdata 0x80FF_FFFF -> bus_be 1111, load_data_m=0xFFFFFF80; same access as LBU -> 0x00000080.
REQ-039 SH, addr 0x22, write_data 0x1234ABCD, ack after 4 cycles -> bus_be 1100, bus_wdata 0xABCDABCD, bus_we 1, stall held for 5 cycles then 0.
REQ-040 LW, addr 0x102 -> misaligned_m=1, bus_req never asserted, stall_m=0.
REQ-041 Assert reset in WAIT, then pulse bus_ack next cycle -> bus_req=0 immediately, FSM in IDLE, no DONE cycle.
REQ-042 Back-to-back SW then LW, ack immediate -> two complete IDLE/WAIT/DONE sequences, 6 cycles total, correct data.
